// File: rtl/decimal_entry_encoder.sv
// rtl/decimal_entry_encoder.sv - keypad BCD digit accumulator with valid/ack operand handoff
// Digits arrive MSD first; clear > enter > digit_valid within a cycle.
module decimal_entry_encoder #(
   parameter int WIDTH      = 14,
   parameter int MAX_DIGITS = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [3:0]       i_digit_in,
   input  logic             i_digit_valid,
   input  logic             i_enter,
   input  logic             i_clear,
   input  logic             i_value_ack,
   output logic [WIDTH-1:0] o_value_out,
   output logic             o_value_valid,
   output logic [WIDTH-1:0] o_acc_out,
   output logic [2:0]       o_ndigits,
   output logic             o_entry_active,
   output logic             o_err_digit,
   output logic             o_err_overflow
);

   typedef enum logic [1:0] {IDLE, ENTRY, DONE} state_t;

   state_t           r_state, w_state_next;
   logic [WIDTH-1:0] r_acc, w_acc_next;
   logic [WIDTH-1:0] r_value, w_value_next;
   logic [2:0]       r_nd, w_nd_next;
   logic             r_valid, w_valid_next;
   logic             r_entry_active;
   logic             r_err_digit, w_err_digit_next;
   logic             r_err_overflow, w_err_overflow_next;
   logic [WIDTH-1:0] w_acc_mac;

   // ndigits is bounded, so this never wraps past 10^MAX_DIGITS - 1
   assign w_acc_mac = (r_acc << 3) + (r_acc << 1) + WIDTH'(i_digit_in);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state        <= IDLE;
         r_acc          <= '0;
         r_value        <= '0;
         r_nd           <= '0;
         r_valid        <= 1'b0;
         r_entry_active <= 1'b0;
         r_err_digit    <= 1'b0;
         r_err_overflow <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_acc          <= w_acc_next;
         r_value        <= w_value_next;
         r_nd           <= w_nd_next;
         r_valid        <= w_valid_next;
         r_entry_active <= (w_state_next == ENTRY);
         r_err_digit    <= w_err_digit_next;
         r_err_overflow <= w_err_overflow_next;
      end
   end

   always_comb begin
      w_state_next        = r_state;
      w_acc_next          = r_acc;
      w_value_next        = r_value;
      w_nd_next           = r_nd;
      w_valid_next        = r_valid;
      w_err_digit_next    = 1'b0;
      w_err_overflow_next = 1'b0;
      if (i_clear) begin
         w_state_next = IDLE;
         w_acc_next   = '0;
         w_nd_next    = '0;
         w_valid_next = 1'b0;
      end else begin
         case (r_state)
            IDLE, ENTRY: begin
               if (i_enter) begin
                  // enter from IDLE is swallowed: no zero-digit operands
                  if (r_state == ENTRY) begin
                     w_value_next = r_acc;
                     w_valid_next = 1'b1;
                     w_state_next = DONE;
                  end
               end else if (i_digit_valid) begin
                  if (i_digit_in > 4'd9) begin
                     w_err_digit_next = 1'b1;
                  end else if (r_nd == 3'(MAX_DIGITS)) begin
                     w_err_overflow_next = 1'b1;
                  end else begin
                     w_acc_next   = w_acc_mac;
                     w_nd_next    = r_nd + 3'd1;
                     w_state_next = ENTRY;
                  end
               end
            end
            DONE: begin
               if (i_value_ack) begin
                  w_valid_next = 1'b0;
                  w_acc_next   = '0;
                  w_nd_next    = '0;
                  w_state_next = IDLE;
               end
            end
            default: w_state_next = IDLE;
         endcase
      end
   end

   assign o_value_out    = r_value;
   assign o_value_valid  = r_valid;
   assign o_acc_out      = r_acc;
   assign o_ndigits      = r_nd;
   assign o_entry_active = r_entry_active;
   assign o_err_digit    = r_err_digit;
   assign o_err_overflow = r_err_overflow;

endmodule

// File: tb/tb_decimal_entry_encoder.sv
// tb/tb_decimal_entry_encoder.sv - self-checking bench for decimal_entry_encoder
// Arithmetic reference model compared on every falling edge, plus directed literal checks.
module tb_decimal_entry_encoder;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic [3:0]  i_digit_in;
   logic        i_digit_valid, i_enter, i_clear, i_value_ack;
   logic [13:0] o_value_out, o_acc_out;
   logic        o_value_valid, o_entry_active, o_err_digit, o_err_overflow;
   logic [2:0]  o_ndigits;

   decimal_entry_encoder #(.WIDTH(14), .MAX_DIGITS(4)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_digit_in(i_digit_in),
      .i_digit_valid(i_digit_valid), .i_enter(i_enter), .i_clear(i_clear),
      .i_value_ack(i_value_ack), .o_value_out(o_value_out),
      .o_value_valid(o_value_valid), .o_acc_out(o_acc_out), .o_ndigits(o_ndigits),
      .o_entry_active(o_entry_active), .o_err_digit(o_err_digit),
      .o_err_overflow(o_err_overflow)
   );

   always #5 i_clk = ~i_clk;

   int total = 0;
   int bad = 0;
   bit run_cmp = 1'b0;

   // model: phase 0 empty, 1 collecting, 2 holding committed operand
   int m_phase, m_acc, m_nd, m_val, m_valid, m_errd, m_erro;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_phase = 0; m_acc = 0; m_nd = 0; m_val = 0; m_valid = 0; m_errd = 0; m_erro = 0;
   endfunction

   function automatic void model_step(int d, bit dv, bit en, bit clr, bit ack);
      m_errd = 0;
      m_erro = 0;
      if (clr) begin
         m_phase = 0; m_acc = 0; m_nd = 0; m_valid = 0;
      end else if (m_phase == 2) begin
         if (ack) begin
            m_phase = 0; m_acc = 0; m_nd = 0; m_valid = 0;
         end
      end else if (en) begin
         if (m_phase == 1) begin
            m_val = m_acc; m_valid = 1; m_phase = 2;
         end
      end else if (dv) begin
         if (d > 9) m_errd = 1;
         else if (m_nd == 4) m_erro = 1;
         else begin
            m_acc = m_acc * 10 + d; m_nd++; m_phase = 1;
         end
      end
   endfunction

   always @(negedge i_clk) begin
      if (run_cmp) begin
         check("acc_out", int'(o_acc_out), m_acc);
         check("ndigits", int'(o_ndigits), m_nd);
         check("value_out", int'(o_value_out), m_val);
         check("value_valid", int'(o_value_valid), m_valid);
         check("entry_active", int'(o_entry_active), int'(m_phase == 1));
         check("err_digit", int'(o_err_digit), m_errd);
         check("err_overflow", int'(o_err_overflow), m_erro);
      end
   end

   task automatic tick(input int d, input bit dv, input bit en, input bit clr, input bit ack);
      i_digit_in = 4'(d); i_digit_valid = dv; i_enter = en; i_clear = clr; i_value_ack = ack;
      @(posedge i_clk);
      model_step(d, dv, en, clr, ack);
      #1;
      i_digit_in = 4'd0; i_digit_valid = 0; i_enter = 0; i_clear = 0; i_value_ack = 0;
   endtask

   task automatic key(input int d);
      tick(d, 1, 0, 0, 0);
   endtask

   task automatic idle();
      tick(0, 0, 0, 0, 0);
   endtask

   int errd_seen, erro_seen;

   initial begin
      i_reset = 1'b1;
      i_digit_in = 0; i_digit_valid = 0; i_enter = 0; i_clear = 0; i_value_ack = 0;
      model_reset();
      #2;
      check("rst_acc", int'(o_acc_out), 0);
      check("rst_valid", int'(o_value_valid), 0);
      check("rst_entry", int'(o_entry_active), 0);
      @(posedge i_clk); #1;
      i_reset = 1'b0;
      run_cmp = 1'b1;

      key(1); check("acc_1", int'(o_acc_out), 1);
      key(2); check("acc_12", int'(o_acc_out), 12);
      key(3); check("acc_123", int'(o_acc_out), 123);
      key(4); check("acc_1234", int'(o_acc_out), 1234);
      check("nd_4", int'(o_ndigits), 4);
      tick(0, 0, 1, 0, 0);
      check("val_1234", int'(o_value_out), 16'h04D2);
      check("valid_after_enter", int'(o_value_valid), 1);
      check("model_val_1234", m_val, 1234);
      idle(); idle();
      check("valid_held", int'(o_value_valid), 1);
      tick(0, 0, 0, 0, 1);
      check("ack_valid", int'(o_value_valid), 0);
      check("ack_acc", int'(o_acc_out), 0);

      errd_seen = 0; erro_seen = 0;
      key(9); key(9); key(9); key(9);
      key(5); erro_seen += int'(o_err_overflow);
      idle(); erro_seen += int'(o_err_overflow);
      check("ovf_pulses", erro_seen, 1);
      tick(0, 0, 1, 0, 0);
      check("val_9999", int'(o_value_out), 16'h270F);
      tick(0, 0, 0, 0, 1);

      key(4);
      key(12); errd_seen += int'(o_err_digit);
      key(2); errd_seen += int'(o_err_digit);
      check("errd_pulses", errd_seen, 1);
      check("acc_42", int'(o_acc_out), 42);
      check("nd_2", int'(o_ndigits), 2);
      tick(0, 0, 0, 1, 0);

      tick(0, 0, 1, 0, 0);
      check("enter_idle_valid", int'(o_value_valid), 0);
      key(0); key(0);
      tick(0, 0, 1, 0, 0);
      check("zero_val", int'(o_value_out), 0);
      check("zero_valid", int'(o_value_valid), 1);
      tick(0, 0, 0, 0, 1);

      key(3);
      tick(5, 1, 1, 0, 0);
      check("enter_beats_digit", int'(o_value_out), 3);
      check("enter_beats_digit_acc", int'(o_acc_out), 3);
      tick(7, 1, 0, 0, 0);
      check("done_ignores_digit", int'(o_acc_out), 3);
      check("done_no_err", int'(o_err_digit) + int'(o_err_overflow), 0);
      tick(0, 0, 0, 1, 1);
      check("ack_clear_valid", int'(o_value_valid), 0);
      check("ack_clear_nd", int'(o_ndigits), 0);

      key(5); key(6);
      tick(0, 0, 1, 1, 0);
      check("clear_wins_valid", int'(o_value_valid), 0);
      check("clear_wins_acc", int'(o_acc_out), 0);

      key(7); key(8);
      #2;
      i_reset = 1'b1;
      #1;
      model_reset();
      check("async_acc", int'(o_acc_out), 0);
      check("async_nd", int'(o_ndigits), 0);
      check("async_entry", int'(o_entry_active), 0);
      @(posedge i_clk); #1;
      i_reset = 1'b0;
      key(3);
      check("post_reset_acc", int'(o_acc_out), 3);

      for (int n = 0; n < 3000; n++) begin
         int r;
         int d;
         bit c;
         r = int'($urandom_range(0, 99));
         d = int'($urandom_range(0, 11));
         c = ($urandom_range(0, 19) == 0);
         if (r < 55)      tick(d, 1, 0, c, 0);
         else if (r < 65) tick(0, 0, 1, c, 0);
         else if (r < 80) tick(0, 0, 0, c, 1);
         else             tick(0, 0, 0, c, 0);
      end

      @(posedge i_clk); #1;
      run_cmp = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
